// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bus bundle for the scoreboarded register file.
//   write   : we / rd_a / rd_dt in, wr_ready out (accept = we && wr_ready)
//   read    : rs1_a / rs2_a in, rs1_dt / rs2_dt and rs1_pend / rs2_pend out
//   alloc   : alloc_en / alloc_a in (mark destination pending)
//   clear   : clr_req in, clr_busy out
// master = pipeline side (decode/writeback), slave = register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            we;
  logic [AW-1:0]   rd_a;
  logic [XLEN-1:0] rd_dt;
  logic            wr_ready;
  logic [AW-1:0]   rs1_a;
  logic [XLEN-1:0] rs1_dt;
  logic [AW-1:0]   rs2_a;
  logic [XLEN-1:0] rs2_dt;
  logic            rs1_pend;
  logic            rs2_pend;
  logic            alloc_en;
  logic [AW-1:0]   alloc_a;
  logic            clr_req;
  logic            clr_busy;

  modport master (
    output we, rd_a, rd_dt, rs1_a, rs2_a, alloc_en, alloc_a, clr_req,
    input  wr_ready, rs1_dt, rs2_dt, rs1_pend, rs2_pend, clr_busy
  );

  modport slave (
    input  we, rd_a, rd_dt, rs1_a, rs2_a, alloc_en, alloc_a, clr_req,
    output wr_ready, rs1_dt, rs2_dt, rs1_pend, rs2_pend, clr_busy
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with two combinational
// read ports, one clocked write port, optional x0 hardwiring, optional
// write-to-read bypass, a per-register pending-write scoreboard and a
// sequential clear engine that zeroes the array one entry per cycle.
//   clk  : clock, all state on rising edge
//   rest : asynchronous active-high reset
//   bus  : regfile_sb_if.slave (write, read, alloc and clear signals)

// One read port: x0 / bypass / array selection and pending-bit masking.
module regfile_sb_rdport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic [AW-1:0]                  addr_i,
  input  logic [(2**AW)-1:0][XLEN-1:0]   mem_i,
  input  logic [(2**AW)-1:0]             pend_i,
  input  logic                           wr_eff_i,
  input  logic [AW-1:0]                  wr_a_i,
  input  logic [XLEN-1:0]                wr_d_i,
  output logic [XLEN-1:0]                data_o,
  output logic                           pend_o
);
  logic is_zero, hit;

  assign is_zero = ZERO_REG && (addr_i == '0);
  // wr_eff_i already excludes dropped x0 writes and writes during clear
  assign hit     = BYPASS && wr_eff_i && (wr_a_i == addr_i);

  always_comb begin
    data_o = mem_i[addr_i];
    pend_o = pend_i[addr_i];
    if (is_zero) begin
      data_o = '0;
      pend_o = 1'b0;
    end else if (hit) begin
      data_o = wr_d_i;
      pend_o = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic         clk,
  input  logic         rest,
  regfile_sb_if.slave  bus
);
  localparam int NREG  = 2**AW;
  localparam int NRD   = 2;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [NREG-1:0][XLEN-1:0]  mem_q;
  logic [NREG-1:0]            pend_q;
  logic                       busy, wr_acc, wr_eff, alloc_ok;

  assign busy         = (state_q == S_CLEAR);
  assign bus.clr_busy = busy;
  assign bus.wr_ready = !busy;
  assign wr_acc       = bus.we && !busy;
  assign wr_eff       = wr_acc && !(ZERO_REG && (bus.rd_a == '0));
  assign alloc_ok     = bus.alloc_en && !(ZERO_REG && (bus.alloc_a == '0));

  // Clear FSM: cnt walks 0..NREG-1; terminal compare avoids any wrap.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array: clear engine owns the write path while busy, so no conflict.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      mem_q <= '0;
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_eff) begin
      mem_q[bus.rd_a] <= bus.rd_dt;
    end
  end

  // Scoreboard: clear start wipes everything; otherwise alloc beats write
  // on the same entry (the new producer wins). Frozen during clear.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      pend_q <= '0;
    end else if (!busy) begin
      if (bus.clr_req) begin
        pend_q <= '0;
      end else begin
        if (wr_eff)   pend_q[bus.rd_a]    <= 1'b0;
        if (alloc_ok) pend_q[bus.alloc_a] <= 1'b1;
      end
    end
  end

  logic [NRD-1:0][AW-1:0]   rs_a;
  logic [NRD-1:0][XLEN-1:0] rs_dt;
  logic [NRD-1:0]           rs_pend;

  assign rs_a[0]      = bus.rs1_a;
  assign rs_a[1]      = bus.rs2_a;
  assign bus.rs1_dt   = rs_dt[0];
  assign bus.rs2_dt   = rs_dt[1];
  assign bus.rs1_pend = rs_pend[0];
  assign bus.rs2_pend = rs_pend[1];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_sb_rdport #(
      .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .addr_i   (rs_a[p]),
      .mem_i    (mem_q),
      .pend_i   (pend_q),
      .wr_eff_i (wr_eff),
      .wr_a_i   (bus.rd_a),
      .wr_d_i   (bus.rd_dt),
      .data_o   (rs_dt[p]),
      .pend_o   (rs_pend[p])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic clk = 1'b0;
  logic rest;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();
  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus_nb ();

  // second instance without bypass shares all stimulus
  assign bus_nb.we       = bus.we;
  assign bus_nb.rd_a     = bus.rd_a;
  assign bus_nb.rd_dt    = bus.rd_dt;
  assign bus_nb.rs1_a    = bus.rs1_a;
  assign bus_nb.rs2_a    = bus.rs2_a;
  assign bus_nb.alloc_en = bus.alloc_en;
  assign bus_nb.alloc_a  = bus.alloc_a;
  assign bus_nb.clr_req  = bus.clr_req;

  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rest(rest), .bus(bus));
  regfile_sb #(.XLEN(XLEN), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rest(rest), .bus(bus_nb));

  // [d] d=0 bypass instance, d=1 no-bypass instance; [p] read port
  logic [1:0][1:0][XLEN-1:0] got_dt;
  logic [1:0][1:0]           got_pend;
  logic [1:0]                got_rdy, got_busy;
  logic [1:0][AW-1:0]        rs_a;
  assign got_dt[0][0] = bus.rs1_dt;    assign got_dt[0][1] = bus.rs2_dt;
  assign got_dt[1][0] = bus_nb.rs1_dt; assign got_dt[1][1] = bus_nb.rs2_dt;
  assign got_pend[0][0] = bus.rs1_pend;    assign got_pend[0][1] = bus.rs2_pend;
  assign got_pend[1][0] = bus_nb.rs1_pend; assign got_pend[1][1] = bus_nb.rs2_pend;
  assign got_rdy  = {bus_nb.wr_ready, bus.wr_ready};
  assign got_busy = {bus_nb.clr_busy, bus.clr_busy};
  assign rs_a     = {bus.rs2_a, bus.rs1_a};

  // Reference model: array contents, pending flags, cycles of clear left.
  logic [XLEN-1:0] m_mem [NREG];
  bit              m_pend[NREG];
  int              m_left;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_left = 0;
  endfunction

  function automatic void model_edge();
    if (m_left > 0) begin
      m_mem[NREG - m_left] = '0;
      m_left--;
    end else begin
      if (bus.we && bus.rd_a != 0) begin
        m_mem[bus.rd_a]  = bus.rd_dt;
        m_pend[bus.rd_a] = 1'b0;
      end
      if (bus.alloc_en && bus.alloc_a != 0) m_pend[bus.alloc_a] = 1'b1;
      if (bus.clr_req) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_left = NREG;
      end
    end
  endfunction

  function automatic bit wr_now(int a);
    return (m_left == 0) && bus.we && (bus.rd_a == a) && (a != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rd(int a, bit byp);
    if (a == 0) return '0;
    if (byp && wr_now(a)) return bus.rd_dt;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(int a, bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_now(a)) return 1'b0;
    return m_pend[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    bus.we = 1'b0; bus.rd_a = '0; bus.rd_dt = '0;
    bus.alloc_en = 1'b0; bus.alloc_a = '0; bus.clr_req = 1'b0;
    bus.rs1_a = '0; bus.rs2_a = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rest = 1'b1;
    model_reset();
    #12;
    for (int k = 0; k < 4; k++) begin
      bus.rs1_a = AW'($urandom); bus.rs2_a = AW'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (got_rdy[d] !== 1'b1 || got_busy[d] !== 1'b0) begin
          n_err++; $display("FAIL reset_ctl d%0d: rdy=%b busy=%b want 1/0", d, got_rdy[d], got_busy[d]);
        end
        for (int p = 0; p < 2; p++) begin
          n_chk++;
          if (got_dt[d][p] !== '0 || got_pend[d][p] !== 1'b0) begin
            n_err++; $display("FAIL reset_rd d%0d p%0d: dt=%h pend=%b want 0/0", d, p, got_dt[d][p], got_pend[d][p]);
          end
        end
      end
    end
    rest = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    bus.we = 1'b1; bus.rd_a = 5'd5; bus.rd_dt = 32'hDEADBEEF;
    tick();
    bus.we = 1'b0; bus.rs1_a = 5'd5; bus.rs2_a = 5'd0;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_x5: got %h want deadbeef", bus.rs1_dt);
    end
    n_chk++;
    if (bus.rs2_dt !== 32'h0) begin
      n_err++; $display("FAIL rd_x0: got %h want 0", bus.rs2_dt);
    end
    bus.we = 1'b1; bus.rd_a = 5'd0; bus.rd_dt = 32'h1234; bus.rs1_a = 5'd0;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'h0) begin
      n_err++; $display("FAIL x0_nobypass: got %h want 0", bus.rs1_dt);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'h0 || bus_nb.rs1_dt !== 32'h0) begin
      n_err++; $display("FAIL x0_write: got %h/%h want 0", bus.rs1_dt, bus_nb.rs1_dt);
    end
  endtask

  task automatic test_bypass();
    bus.we = 1'b1; bus.rd_a = 5'd7; bus.rd_dt = 32'h11;
    tick();
    bus.rd_dt = 32'h22; bus.rs1_a = 5'd7;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'h22) begin
      n_err++; $display("FAIL bypass_on: got %h want 22", bus.rs1_dt);
    end
    n_chk++;
    if (bus_nb.rs1_dt !== 32'h11) begin
      n_err++; $display("FAIL bypass_off: got %h want 11", bus_nb.rs1_dt);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'h22 || bus_nb.rs1_dt !== 32'h22) begin
      n_err++; $display("FAIL bypass_next: got %h/%h want 22", bus.rs1_dt, bus_nb.rs1_dt);
    end
  endtask

  task automatic test_scoreboard();
    bus.alloc_en = 1'b1; bus.alloc_a = 5'd3; bus.rs2_a = 5'd3;
    tick();
    bus.alloc_en = 1'b0;
    #1;
    n_chk++;
    if (bus.rs2_pend !== 1'b1 || bus_nb.rs2_pend !== 1'b1) begin
      n_err++; $display("FAIL alloc_pend: got %b/%b want 1", bus.rs2_pend, bus_nb.rs2_pend);
    end
    bus.we = 1'b1; bus.rd_a = 5'd3; bus.rd_dt = 32'h33;
    #1;
    n_chk++;
    if (bus.rs2_pend !== 1'b0 || bus_nb.rs2_pend !== 1'b1) begin
      n_err++; $display("FAIL wr_cycle_pend: got %b/%b want 0/1", bus.rs2_pend, bus_nb.rs2_pend);
    end
    tick();
    bus.we = 1'b0;
    #1;
    n_chk++;
    if (bus.rs2_pend !== 1'b0 || bus_nb.rs2_pend !== 1'b0) begin
      n_err++; $display("FAIL wr_clears_pend: got %b/%b want 0", bus.rs2_pend, bus_nb.rs2_pend);
    end
    bus.we = 1'b1; bus.rd_dt = 32'h44; bus.alloc_en = 1'b1; bus.alloc_a = 5'd3;
    tick();
    bus.we = 1'b0; bus.alloc_en = 1'b0;
    #1;
    n_chk++;
    if (bus.rs2_pend !== 1'b1 || bus_nb.rs2_pend !== 1'b1) begin
      n_err++; $display("FAIL alloc_wins: got %b/%b want 1", bus.rs2_pend, bus_nb.rs2_pend);
    end
  endtask

  // Counts busy cycles from the current (post-clr_req) cycle; leaves the
  // bench in the first idle cycle without ticking past it.
  task automatic count_clear(input string tag);
    int busy_n = 0;
    int rdy_lo = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (got_busy[0]) busy_n++;
      if (!got_rdy[0]) rdy_lo++;
      if (!got_busy[0]) break;
      tick();
    end
    n_chk++;
    if (busy_n != NREG || rdy_lo != NREG) begin
      n_err++; $display("FAIL %s_len: busy=%0d rdy_low=%0d want %0d", tag, busy_n, rdy_lo, NREG);
    end
  endtask

  task automatic test_clear();
    for (int a = 1; a < NREG; a++) begin
      bus.we = 1'b1; bus.rd_a = AW'(a); bus.rd_dt = $urandom | 32'h1;
      tick();
      bus.we = 1'b0; bus.alloc_en = 1'b1; bus.alloc_a = AW'(a);
      tick();
      bus.alloc_en = 1'b0;
    end
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    bus.we = 1'b1; bus.rd_a = 5'd9; bus.rd_dt = 32'hCAFE0009;
    bus.alloc_en = 1'b1; bus.alloc_a = 5'd4;
    count_clear("clear");
    bus.alloc_en = 1'b0; bus.rs1_a = 5'd9;
    #1;
    n_chk++;
    if (bus.rs1_dt !== 32'hCAFE0009 || bus_nb.rs1_dt !== 32'h0) begin
      n_err++; $display("FAIL held_write: got %h/%h want cafe0009/0", bus.rs1_dt, bus_nb.rs1_dt);
    end
    tick();
    bus.we = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      bus.rs1_a = AW'(a); bus.rs2_a = AW'(a);
      #1;
      n_chk++;
      if (bus_nb.rs1_dt !== ((a == 9) ? 32'hCAFE0009 : 32'h0) || bus.rs2_pend !== 1'b0
          || bus_nb.rs2_pend !== 1'b0) begin
        n_err++; $display("FAIL cleared x%0d: dt=%h pend=%b/%b", a, bus_nb.rs1_dt, bus.rs2_pend, bus_nb.rs2_pend);
      end
    end
  endtask

  task automatic test_reset_midclear();
    for (int a = 1; a < 9; a++) begin
      bus.we = 1'b1; bus.rd_a = AW'(a); bus.rd_dt = $urandom | 32'h1;
      tick();
    end
    bus.we = 1'b0; bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    rest = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (got_busy[d] !== 1'b0 || got_rdy[d] !== 1'b1) begin
        n_err++; $display("FAIL midclear_rst d%0d: busy=%b rdy=%b want 0/1", d, got_busy[d], got_rdy[d]);
      end
    end
    for (int a = 0; a < 16; a++) begin
      bus.rs1_a = AW'(a); bus.rs2_a = AW'(a + 16);
      #1;
      n_chk++;
      if (got_dt !== '0) begin
        n_err++; $display("FAIL midclear_rd x%0d: got %h want 0", a, got_dt);
      end
    end
    rest = 1'b0;
    tick();
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    count_clear("reclear");
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.we       = ($urandom_range(0, 99) < 60);
      bus.rd_a     = AW'($urandom);
      bus.rd_dt    = $urandom;
      bus.alloc_en = ($urandom_range(0, 99) < 40);
      bus.alloc_a  = AW'($urandom);
      bus.clr_req  = ($urandom_range(0, 99) < 2);
      bus.rs1_a    = ($urandom_range(0, 3) == 0) ? bus.rd_a : AW'($urandom);
      bus.rs2_a    = ($urandom_range(0, 3) == 0) ? bus.alloc_a : AW'($urandom);
      #1;
      for (int d = 0; d < 2; d++) begin
        n_chk++;
        if (got_rdy[d] !== (m_left == 0) || got_busy[d] !== (m_left != 0)) begin
          n_err++; $display("FAIL rnd_ctl c%0d d%0d: rdy=%b busy=%b left=%0d", c, d, got_rdy[d], got_busy[d], m_left);
        end
        for (int p = 0; p < 2; p++) begin
          n_chk++;
          if (got_dt[d][p] !== exp_rd(rs_a[p], d == 0) || got_pend[d][p] !== exp_pend(rs_a[p], d == 0)) begin
            n_err++; $display("FAIL rnd_rd c%0d d%0d p%0d a=%0d: dt=%h pend=%b want %h/%b", c, d, p, rs_a[p],
                              got_dt[d][p], got_pend[d][p], exp_rd(rs_a[p], d == 0), exp_pend(rs_a[p], d == 0));
          end
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_clear();
    test_reset_midclear();
    drive_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the RV32I integer register file: 2 combinational read ports, 1 clocked write port, and configurable width, depth, x0 hardwiring and write-to-read bypass.
- Adds a per-register pending-write scoreboard for hazard detection and a sequential clear engine that zeroes the whole array without a reset.
- Sits between decode (reads, allocation) and writeback (writes) in the core pipeline.

Parameters:
- XLEN, 32, data width in bits.
- AW, 5, address width; depth NREG = 2**AW.
- ZERO_REG, 1, 1: entry 0 reads 0, ignores writes and ignores allocation.
- BYPASS, 1, 1: a same-cycle accepted write to a read address is forwarded to that read port.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rest  in  1  reset, asynchronous, active-high.
- we  in  1  write request.
- rd_a  in  AW  write address.
- rd_dt  in  XLEN  write data.
- wr_ready  out  1  write accept; a write is accepted when we && wr_ready.
- rs1_a  in  AW  read port 1 address.
- rs1_dt  out  XLEN  read port 1 data.
- rs2_a  in  AW  read port 2 address.
- rs2_dt  out  XLEN  read port 2 data.
- rs1_pend  out  1  register at rs1_a has an outstanding producer.
- rs2_pend  out  1  register at rs2_a has an outstanding producer.
- alloc_en  in  1  mark a destination register pending.
- alloc_a  in  AW  destination register to mark pending.
- clr_req  in  1  start a full-array clear.
- clr_busy  out  1  clear in progress.

Behaviour:
- Reset:
  - rest=1 asynchronously zeroes all NREG entries and all pend bits, sets FSM to IDLE and clear counter to 0.
  - Outputs: wr_ready=1, clr_busy=0; rs*_dt=0 and rs*_pend=0 for any address.
  - Reset mid-clear aborts the clear; the end state is the same as any reset.
- Write:
  - An accepted write with address 0 and ZERO_REG=1 is dropped.
  - Otherwise mem[rd_a] <= rd_dt at the edge, visible to reads in the next cycle.
  - A write presented with wr_ready=0 is not performed; the producer holds we/rd_a/rd_dt until accepted.
- Read (combinational, zero latency):
  - Address 0 with ZERO_REG=1 returns 0.
  - Else, if BYPASS=1 and an accepted, non-dropped write targets the same address this cycle, return rd_dt.
  - Else return mem[addr].
  - Both ports are independent; the same address on both ports is legal.
- Scoreboard:
  - pend[i] is set at the edge by alloc_en && alloc_a==i (ignored for i=0 when ZERO_REG=1).
  - pend[i] is cleared by an accepted write to i.
  - Alloc and write to the same address in the same cycle: pend ends set (the new producer wins).
  - rsN_pend = pend[rsN_a], forced 0 when:
    - ZERO_REG=1 and the address is 0; or
    - BYPASS=1 and an accepted write to that address is occurring this cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 at an edge moves to CLEAR, cnt=0, and clears all pend bits at that same edge.
  - CLEAR: each edge writes mem[cnt]=0 and increments cnt. At cnt==NREG-1 the state returns to IDLE and cnt=0.
  - clr_busy=1 exactly while in CLEAR, i.e. NREG cycles.
  - wr_ready = !clr_busy.
  - In CLEAR, clr_req and alloc_en are ignored.
  - Reads during CLEAR return current (partially cleared) contents with no bypass, because no write is accepted.
  - A write accepted in the same cycle clr_req is sampled in IDLE is performed; its target entry is zeroed later in CLEAR.
- Widths: the counter is AW+1 bits, or AW bits with explicit terminal compare; there is no wrap beyond NREG-1.

Test Plan:
- Reset, then write x5=0xDEADBEEF -> next cycle rs1_a=5 reads 0xDEADBEEF; rs2_a=0 reads 0; write x0=0x1234 -> x0 still reads 0.
- BYPASS=1: x7 holds 0x11; same cycle we, rd_a=7, rd_dt=0x22, rs1_a=7 -> rs1_dt=0x22 combinationally. BYPASS=0: rs1_dt=0x11, then 0x22 next cycle.
- alloc x3 -> rs2_pend=1 on the next cycle; a write to x3 clears it (0 in the write cycle if BYPASS=1, else from the next cycle). Alloc and write to x3 in the same cycle -> pend stays 1.
- AW=5: fill x1..x31 with nonzero data, pulse clr_req -> clr_busy high exactly 32 cycles and wr_ready low for the same 32 cycles; a held write is accepted on the first cycle after; all entries read 0; all pend bits 0.
- Assert rest asynchronously (between edges) at cycle 10 of a clear -> immediately clr_busy=0, wr_ready=1, all reads 0; a new clr_req afterwards runs the full 32 cycles.
